// File: rtl/load_store_unit_rv32i.sv
// RV32I load/store unit. It checks alignment, issues one request at a time on a
// req/gnt/rvalid memory port, and returns extended scalar or multi-beat vector data.
module load_store_unit_rv32i #(
  parameter int ADDR_W = 32,
  parameter int VBEATS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   is_store,
  input  logic [2:0]             width,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [31:0]            st_data,
  input  logic [VBEATS*32-1:0]   st_vdata,
  output logic                   resp_valid,
  output logic                   resp_err,
  output logic [31:0]            ld_data,
  output logic [VBEATS*32-1:0]   ld_vdata,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [3:0]             mem_be,
  output logic [31:0]            mem_wdata,
  input  logic                   mem_gnt,
  input  logic                   mem_rvalid,
  input  logic [31:0]            mem_rdata
);
  localparam int BW = (VBEATS > 1) ? $clog2(VBEATS) : 1;
  localparam logic [2:0] W_B = 3'd0, W_H = 3'd1, W_W = 3'd2, W_BU = 3'd3, W_HU = 3'd4, W_V = 3'd5;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;
  state_t state, state_nxt;

  logic                 is_store_q;
  logic [2:0]           width_q;
  logic                 err_q;
  logic [BW-1:0]        beat;
  logic [ADDR_W-1:0]    addr_q;
  logic [31:0]          st_data_q;
  logic [VBEATS*32-1:0] st_vdata_q;
  logic                 accept, misaligned, last_beat, beat_done;

  function automatic logic misalign(input logic [2:0] w, input logic [3:0] a);
    case (w)
      W_B, W_BU: misalign = 1'b0;
      W_H, W_HU: misalign = a[0];
      W_W:       misalign = |a[1:0];
      W_V:       misalign = |a;
      default:   misalign = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] extract_lane(input logic [2:0] w, input logic [1:0] a,
                                               input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[8*a +: 8];
    h = a[1] ? d[31:16] : d[15:0];
    case (w)
      W_B:     extract_lane = {{24{b[7]}}, b};
      W_BU:    extract_lane = {24'b0, b};
      W_H:     extract_lane = {{16{h[15]}}, h};
      W_HU:    extract_lane = {16'b0, h};
      default: extract_lane = d;
    endcase
  endfunction

  assign accept     = (state == IDLE) && req_valid;
  assign misaligned = misalign(width, addr[3:0]);
  assign last_beat  = (width_q != W_V) || (beat == BW'(VBEATS - 1));
  assign beat_done  = ((state == REQ) && mem_gnt && is_store_q) || ((state == WAIT_R) && mem_rvalid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    mem_req    = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = misaligned ? RESP : REQ;
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) state_nxt = !is_store_q ? WAIT_R : (last_beat ? RESP : REQ);
      end
      WAIT_R: if (mem_rvalid) state_nxt = last_beat ? RESP : REQ;
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory port drive: only meaningful while a request is outstanding, zero otherwise
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = 4'b0000;
    mem_wdata = 32'b0;
    if (state == REQ) begin
      mem_we   = is_store_q;
      mem_addr = {addr_q[ADDR_W-1:2], 2'b00} + (ADDR_W'(beat) << 2);
      case (width_q)
        W_B, W_BU: begin
          mem_be    = 4'b0001 << addr_q[1:0];
          mem_wdata = {4{st_data_q[7:0]}};
        end
        W_H, W_HU: begin
          mem_be    = 4'b0011 << addr_q[1:0];
          mem_wdata = {2{st_data_q[15:0]}};
        end
        W_V: begin
          mem_be    = 4'hF;
          mem_wdata = st_vdata_q[32*beat +: 32];
        end
        default: begin
          mem_be    = 4'hF;
          mem_wdata = st_data_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_store_q <= 1'b0;
      width_q    <= 3'd0;
      err_q      <= 1'b0;
      beat       <= '0;
      ld_data    <= 32'b0;
      ld_vdata   <= '0;
    end else begin
      if (accept) begin
        is_store_q <= is_store;
        width_q    <= width;
        err_q      <= misaligned;
        beat       <= '0;
      end else if (beat_done) begin
        beat <= beat + 1'b1;
      end
      if ((state == WAIT_R) && mem_rvalid) begin
        if (width_q == W_V) ld_vdata[32*beat +: 32] <= mem_rdata;
        else                ld_data <= extract_lane(width_q, addr_q[1:0], mem_rdata);
      end
    end
  end

  // Request operands: only observed while busy, so no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q     <= addr;
      st_data_q  <= st_data;
      st_vdata_q <= st_vdata;
    end
  end
endmodule

// File: tb/tb_load_store_unit_rv32i.sv
// Self-checking bench for load_store_unit_rv32i: directed scenarios plus a randomized
// run against a byte-addressed reference memory.
module tb_load_store_unit_rv32i;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         is_store = 1'b0;
  logic [2:0]   width = 3'd0;
  logic [31:0]  addr = 32'h0;
  logic [31:0]  st_data = 32'h0;
  logic [127:0] st_vdata = 128'h0;
  logic         mem_gnt = 1'b0;
  logic         mem_rvalid = 1'b0;
  logic [31:0]  mem_rdata = 32'h0;
  logic         req_ready, resp_valid, resp_err, mem_req, mem_we;
  logic [31:0]  ld_data, mem_addr, mem_wdata;
  logic [127:0] ld_vdata;
  logic [3:0]   mem_be;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_words [0:63];
  logic [7:0]  ref_mem [0:255];
  int          gdly [0:3];
  int          rvdly [0:3];
  bit          poke = 1'b0;

  int          obs_lat, obs_nreq;
  logic        obs_err, obs_stable, obs_ready_seen, obs_we;
  logic [31:0] obs_addr [0:7];
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata;

  load_store_unit_rv32i #(.ADDR_W(32), .VBEATS(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .is_store(is_store), .width(width), .addr(addr), .st_data(st_data), .st_vdata(st_vdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .ld_data(ld_data), .ld_vdata(ld_vdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Issues one request and plays the memory side; starts and ends at a negedge in IDLE.
  task automatic run_txn(input logic st, input logic [2:0] w, input logic [31:0] a,
                         input logic [31:0] sd, input logic [127:0] svd);
    int cyc, bt, wcnt, rwait;
    bit in_req, rd_pend, done;
    logic [31:0] f_addr, f_wdata, rd_addr;
    logic [3:0]  f_be;
    logic        f_we;
    obs_lat = -1; obs_nreq = 0; obs_err = 1'b0; obs_stable = 1'b1; obs_ready_seen = 1'b0;
    obs_be = 4'h0; obs_wdata = 32'h0; obs_we = 1'b0;
    for (int i = 0; i < 8; i++) obs_addr[i] = 32'h0;
    bt = 0; wcnt = 0; rwait = 0; in_req = 0; rd_pend = 0; done = 0;
    f_addr = 0; f_wdata = 0; f_be = 0; f_we = 0; rd_addr = 0;
    is_store = st; width = w; addr = a; st_data = sd; st_vdata = svd; req_valid = 1'b1;
    @(negedge clk);
    if (poke) begin width = 3'd7; addr = 32'h5; end
    else req_valid = 1'b0;
    for (cyc = 1; cyc < 100 && !done; cyc++) begin
      if (poke && req_ready) obs_ready_seen = 1'b1;
      if (resp_valid) begin
        obs_lat = cyc; obs_err = resp_err; done = 1;
        req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      end else begin
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        if (rd_pend) begin
          if (rwait >= rvdly[bt % 4]) begin
            mem_rvalid = 1'b1; mem_rdata = mem_words[rd_addr[7:2]]; rd_pend = 0; bt++;
          end else rwait++;
        end
        if (mem_req) begin
          if (!in_req) begin
            in_req = 1; wcnt = 0;
            f_addr = mem_addr; f_be = mem_be; f_wdata = mem_wdata; f_we = mem_we;
            if (obs_nreq == 0) begin obs_be = mem_be; obs_wdata = mem_wdata; obs_we = mem_we; end
          end else if (mem_addr !== f_addr || mem_be !== f_be || mem_wdata !== f_wdata || mem_we !== f_we)
            obs_stable = 1'b0;
          if (wcnt >= gdly[bt % 4]) begin
            mem_gnt = 1'b1; in_req = 0;
            if (obs_nreq < 8) obs_addr[obs_nreq] = mem_addr;
            obs_nreq++;
            if (mem_we) begin
              for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem_words[mem_addr[7:2]][8*b +: 8] = mem_wdata[8*b +: 8];
              bt++;
            end else begin
              rd_pend = 1; rwait = 0; rd_addr = mem_addr;
            end
          end else wcnt++;
        end
        @(negedge clk);
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL txn_timeout no resp_valid within 100 cycles (width %0d addr %h)", w, a);
    end
    req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_err, mem_req, mem_we, mem_be} !== 9'b1_0000_0000) begin
      errors++; $display("FAIL reset_ctrl got %b want 100000000", {req_ready, resp_valid, resp_err, mem_req, mem_we, mem_be});
    end
    checks++;
    if ({mem_addr, mem_wdata, ld_data, ld_vdata} !== '0) begin
      errors++; $display("FAIL reset_data got %h %h %h %h want 0", mem_addr, mem_wdata, ld_data, ld_vdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      errors++; $display("FAIL reset_release got %b want 10", {req_ready, resp_valid});
    end
  endtask

  task automatic test_signed_byte_load();
    for (int k = 0; k < 4; k++) begin gdly[k] = 0; rvdly[k] = 0; end
    mem_words[0] = 32'h80123456;
    run_txn(1'b0, 3'd0, 32'h103, 32'h0, 128'h0);
    checks++; if (obs_lat !== 3) begin errors++; $display("FAIL sbyte_lat got %0d want 3", obs_lat); end
    checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL sbyte_err got %b want 0", obs_err); end
    checks++; if (obs_addr[0] !== 32'h100) begin errors++; $display("FAIL sbyte_addr got %h want 100", obs_addr[0]); end
    checks++; if (obs_be !== 4'b1000) begin errors++; $display("FAIL sbyte_be got %b want 1000", obs_be); end
    checks++; if (obs_we !== 1'b0) begin errors++; $display("FAIL sbyte_we got %b want 0", obs_we); end
    checks++; if (ld_data !== 32'hFFFFFF80) begin errors++; $display("FAIL sbyte_data got %h want ffffff80", ld_data); end
  endtask

  task automatic test_unsigned_half_load();
    mem_words[0] = 32'hBEEF0000;
    run_txn(1'b0, 3'd4, 32'h202, 32'h0, 128'h0);
    checks++; if (obs_lat !== 3) begin errors++; $display("FAIL uhalf_lat got %0d want 3", obs_lat); end
    checks++; if (obs_be !== 4'b1100) begin errors++; $display("FAIL uhalf_be got %b want 1100", obs_be); end
    checks++; if (ld_data !== 32'h0000BEEF) begin errors++; $display("FAIL uhalf_data got %h want 0000beef", ld_data); end
  endtask

  task automatic test_half_store();
    mem_words[4] = 32'h11223344;
    run_txn(1'b1, 3'd1, 32'h12, 32'h1234ABCD, 128'h0);
    checks++; if (obs_lat !== 2) begin errors++; $display("FAIL hstore_lat got %0d want 2", obs_lat); end
    checks++; if (obs_we !== 1'b1) begin errors++; $display("FAIL hstore_we got %b want 1", obs_we); end
    checks++; if (obs_be !== 4'b1100) begin errors++; $display("FAIL hstore_be got %b want 1100", obs_be); end
    checks++; if (obs_wdata !== 32'hABCDABCD) begin errors++; $display("FAIL hstore_wdata got %h want abcdabcd", obs_wdata); end
    checks++; if (mem_words[4] !== 32'hABCD3344) begin errors++; $display("FAIL hstore_mem got %h want abcd3344", mem_words[4]); end
    checks++; if (ld_data !== 32'h0000BEEF) begin errors++; $display("FAIL hstore_ld_hold got %h want 0000beef", ld_data); end
  endtask

  task automatic test_misaligned();
    logic [2:0]  ws [0:2];
    logic [31:0] as [0:2];
    ws = '{3'd2, 3'd7, 3'd5};
    as = '{32'h6, 32'h0, 32'h48};
    for (int i = 0; i < 3; i++) begin
      run_txn(1'b0, ws[i], as[i], 32'h0, 128'h0);
      checks++; if (obs_nreq !== 0) begin errors++; $display("FAIL misalign%0d_nreq got %0d want 0", i, obs_nreq); end
      checks++; if (obs_lat !== 1) begin errors++; $display("FAIL misalign%0d_lat got %0d want 1", i, obs_lat); end
      checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL misalign%0d_err got %b want 1", i, obs_err); end
    end
    checks++; if (ld_data !== 32'h0000BEEF) begin errors++; $display("FAIL misalign_ld_hold got %h want 0000beef", ld_data); end
  endtask

  task automatic test_vector_load();
    for (int k = 0; k < 4; k++) mem_words[16 + k] = 32'h11111111 * (k + 1);
    gdly = '{0, 2, 0, 0};
    run_txn(1'b0, 3'd5, 32'h40, 32'h0, 128'h0);
    checks++; if (obs_lat !== 11) begin errors++; $display("FAIL vload_lat got %0d want 11", obs_lat); end
    checks++; if (obs_nreq !== 4) begin errors++; $display("FAIL vload_nreq got %0d want 4", obs_nreq); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs_addr[k] !== 32'h40 + 4 * k) begin errors++; $display("FAIL vload_addr%0d got %h want %h", k, obs_addr[k], 32'h40 + 4 * k); end
    end
    checks++; if (obs_stable !== 1'b1) begin errors++; $display("FAIL vload_stable got %b want 1", obs_stable); end
    checks++;
    if (ld_vdata !== 128'h44444444_33333333_22222222_11111111) begin
      errors++; $display("FAIL vload_data got %h want 44444444333333332222222211111111", ld_vdata);
    end
    gdly = '{0, 0, 0, 0};
  endtask

  task automatic test_back_to_back();
    gdly = '{3, 0, 0, 0};
    poke = 1'b1;
    run_txn(1'b1, 3'd2, 32'h20, 32'hCAFEF00D, 128'h0);
    poke = 1'b0;
    checks++; if (obs_ready_seen !== 1'b0) begin errors++; $display("FAIL busy_ready got %b want 0", obs_ready_seen); end
    checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL busy_err got %b want 0", obs_err); end
    checks++; if (obs_lat !== 5) begin errors++; $display("FAIL busy_lat got %0d want 5", obs_lat); end
    checks++; if (obs_stable !== 1'b1) begin errors++; $display("FAIL busy_stable got %b want 1", obs_stable); end
    checks++; if (mem_words[8] !== 32'hCAFEF00D) begin errors++; $display("FAIL busy_mem got %h want cafef00d", mem_words[8]); end
    gdly = '{0, 0, 0, 0};
  endtask

  task automatic test_reset_mid();
    bit resp_seen;
    mem_words[4] = 32'h55667788;
    is_store = 1'b0; width = 3'd2; addr = 32'h10; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rmid_req got %b want 1", mem_req); end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    checks++; if ({mem_req, req_ready} !== 2'b00) begin errors++; $display("FAIL rmid_wait got %b want 00", {mem_req, req_ready}); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_err, mem_req, mem_we, mem_be} !== 9'b1_0000_0000) begin
      errors++; $display("FAIL rmid_ctrl got %b want 100000000", {req_ready, resp_valid, resp_err, mem_req, mem_we, mem_be});
    end
    checks++;
    if ({mem_addr, mem_wdata, ld_data, ld_vdata} !== '0) begin
      errors++; $display("FAIL rmid_data got %h %h %h %h want 0", mem_addr, mem_wdata, ld_data, ld_vdata);
    end
    @(negedge clk);
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    resp_seen = 0;
    repeat (3) begin
      if (resp_valid) resp_seen = 1;
      @(negedge clk);
    end
    checks++; if (resp_seen !== 1'b0) begin errors++; $display("FAIL rmid_stray_resp got %b want 0", resp_seen); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b want 1", req_ready); end
    checks++; if (ld_data !== 32'h0) begin errors++; $display("FAIL rmid_ld got %h want 0", ld_data); end
  endtask

  task automatic test_random();
    logic        st;
    logic [2:0]  w;
    logic [31:0] a, sd, exp_ld, raw, exp_addr;
    logic [127:0] svd, exp_vld;
    int size, beats, exp_lat, x;
    bit exp_err;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_ld = 32'h0; exp_vld = 128'h0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    for (int i = 0; i < 64; i++)
      mem_words[i] = {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
    for (int it = 0; it < 60; it++) begin
      st = 1'($urandom_range(0, 1));
      w  = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (w == 3'd1 || w == 3'd4) a = a & ~32'h1;
        else if (w == 3'd2) a = a & ~32'h3;
        else if (w == 3'd5) a = a & ~32'hF;
      end
      sd  = $urandom;
      svd = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < 4; k++) begin gdly[k] = $urandom_range(0, 2); rvdly[k] = $urandom_range(0, 2); end
      case (w)
        3'd0, 3'd3: size = 1;
        3'd1, 3'd4: size = 2;
        3'd2:       size = 4;
        3'd5:       size = 16;
        default:    size = 0;
      endcase
      exp_err = (size == 0) || (int'(a) % size != 0);
      beats = (w == 3'd5) ? 4 : 1;
      if (exp_err) exp_lat = 1;
      else begin
        exp_lat = st ? beats + 1 : 2 * beats + 1;
        for (int k = 0; k < beats; k++) exp_lat += gdly[k] + (st ? 0 : rvdly[k]);
      end
      run_txn(st, w, a, sd, svd);
      if (!exp_err) begin
        if (st) begin
          for (int i = 0; i < size; i++) ref_mem[int'(a) + i] = (w == 3'd5) ? svd[8*i +: 8] : sd[8*i +: 8];
        end else if (w == 3'd5) begin
          for (int i = 0; i < 16; i++) exp_vld[8*i +: 8] = ref_mem[int'(a) + i];
        end else begin
          raw = 32'h0;
          for (int i = 0; i < size; i++) raw[8*i +: 8] = ref_mem[int'(a) + i];
          x = int'(raw);
          if (w == 3'd0 && x >= 128) x -= 256;
          if (w == 3'd1 && x >= 32768) x -= 65536;
          exp_ld = 32'(x);
        end
      end
      checks++; if (obs_err !== exp_err) begin errors++; $display("FAIL rnd%0d_err got %b want %b", it, obs_err, exp_err); end
      checks++; if (obs_lat !== exp_lat) begin errors++; $display("FAIL rnd%0d_lat got %0d want %0d", it, obs_lat, exp_lat); end
      checks++;
      if (obs_nreq !== (exp_err ? 0 : beats)) begin
        errors++; $display("FAIL rnd%0d_nreq got %0d want %0d", it, obs_nreq, exp_err ? 0 : beats);
      end
      if (!exp_err) begin
        for (int k = 0; k < beats; k++) begin
          exp_addr = (a & ~32'h3) + 32'(4 * k);
          checks++;
          if (obs_addr[k] !== exp_addr) begin errors++; $display("FAIL rnd%0d_addr%0d got %h want %h", it, k, obs_addr[k], exp_addr); end
        end
      end
      checks++; if (ld_data !== exp_ld) begin errors++; $display("FAIL rnd%0d_ld got %h want %h", it, ld_data, exp_ld); end
      checks++; if (ld_vdata !== exp_vld) begin errors++; $display("FAIL rnd%0d_vld got %h want %h", it, ld_vdata, exp_vld); end
    end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (mem_words[i] !== {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]}) begin
        errors++; $display("FAIL rnd_mem%0d got %h want %h", i, mem_words[i],
                          {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]});
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin gdly[k] = 0; rvdly[k] = 0; end
    for (int i = 0; i < 64; i++) mem_words[i] = 32'h0;
    test_reset();
    test_signed_byte_load();
    test_unsigned_half_load();
    test_half_store();
    test_misaligned();
    test_vector_load();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_store_unit_rv32i.md
Name: load_store_unit_rv32i

Overview:
- Sequential memory-access stage directly downstream of the load/store width decoder.
- Takes the 3-bit width code and the load/store qualifiers, plus the address and store data, and checks alignment.
- Drives a 32-bit request/grant/rvalid data-memory port, with byte-enables generated from the width code.
- Returns sign/zero-extended scalar load data, or 128-bit vector data assembled from 4 word beats.

Parameters:
- ADDR_W, 32, byte address width
- VBEATS, 4, words per vector transaction (vector = VBEATS*32 bits)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle, can accept
- is_store  in  1  1=store, 0=load
- width  in  3  0=byte, 1=half, 2=word, 3=byte unsigned, 4=half unsigned, 5=vector, 6/7=illegal
- addr  in  ADDR_W  byte address
- st_data  in  32  scalar store data, low bits used
- st_vdata  in  VBEATS*32  vector store data, beat k = bits [32k+31:32k]
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  misaligned or illegal width, valid with resp_valid
- ld_data  out  32  extended scalar load result
- ld_vdata  out  VBEATS*32  vector load result
- mem_req  out  1  memory request
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  word-aligned address, [1:0]=0
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-shifted write data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE; req_ready=1.
  - All other outputs 0: resp_valid, resp_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata, ld_data, ld_vdata.
  - Beat counter=0.
  - Reset mid-transaction abandons the transaction; a late mem_rvalid after reset is ignored in IDLE.
- States: IDLE, REQ, WAIT_R, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch all inputs.
  - Alignment check:
    - half/half-u: addr[0]=0.
    - word: addr[1:0]=0.
    - vector: addr[3:0]=0.
    - byte: always aligned.
    - width 6/7: error.
  - On error: go to RESP with resp_err=1; no memory request is issued.
  - Otherwise go to REQ.
- REQ:
  - mem_req=1, held with stable addr/be/wdata/we until mem_gnt.
  - mem_addr = {addr[ADDR_W-1:2],2'b00} + 4*beat.
  - mem_be:
    - byte: 1<<addr[1:0].
    - half: 2'b11<<addr[1:0].
    - word/vector: 4'hF.
  - mem_wdata:
    - byte: st_data[7:0] replicated 4x.
    - half: st_data[15:0] replicated 2x.
    - word: st_data.
    - vector: st_vdata beat.
  - On mem_gnt:
    - Store: next beat, or RESP if last beat.
    - Load: go to WAIT_R.
- WAIT_R:
  - mem_req=0.
  - On mem_rvalid, capture the lane:
    - byte: mem_rdata byte addr[1:0], sign-extended (width 0) or zero-extended (3).
    - half: halfword addr[1], sign-extended (1) or zero-extended (4).
    - word: as is.
    - vector: word into ld_vdata beat slot.
  - Then next beat (REQ), or RESP if last beat.
  - Exactly one outstanding request at a time.
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE.
  - ld_data/ld_vdata hold until the next load completes; stores leave them unchanged.
- Latency with zero-wait memory (gnt in the first REQ cycle, rvalid the next cycle):
  - scalar load accept@0 -> resp_valid@3.
  - scalar store -> @2.
  - vector load -> @9.
  - vector store -> @5.
  - error -> @1.
- req_ready=0 in every state except IDLE; requests offered then are not accepted.

Test Plan:
- Signed byte load: width=0, addr=0x103, mem_rdata=0x80_12_34_56 -> mem_be=4'b1000, mem_addr=0x100, ld_data=0xFFFFFF80, resp_valid@3, resp_err=0.
- Unsigned half load: width=4, addr=0x202, mem_rdata=0xBEEF0000 -> mem_be=4'b1100, ld_data=0x0000BEEF.
- Half store: width=1, addr=0x12, st_data=0x1234ABCD -> mem_we=1, mem_be=4'b1100, mem_wdata=0xABCDABCD, resp_valid@2.
- Misaligned word: width=2, addr=0x6 -> no mem_req, resp_valid@1, resp_err=1; width=7 behaves the same.
- Vector load: width=5, addr=0x40, rdata per beat 0x11111111..0x44444444, mem_gnt delayed 2 cycles on beat 1 -> addresses 0x40/44/48/4C, ld_vdata=0x44444444_33333333_22222222_11111111, mem_req held stable while waiting.
- Reset mid-operation: rst_n low in WAIT_R -> all outputs 0 immediately, req_ready=1 after release, stray mem_rvalid produces no resp_valid.
